// File: rtl/nios2_c_onchip_memory_arbiter_pkg.sv
// Shared types and constants for the two-master on-chip memory arbiter.
// Holds the FSM state encoding, requester id and the saturating error-count helper.
package nios2_c_onchip_memory_arbiter_pkg;

    localparam int ERR_W         = 8;
    localparam int DEPTH_DEFAULT = 75000;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    // Adds 0..2 events to the error count, clamping at ERR_MAX.
    function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, inc};
        return sum[ERR_W] ? ERR_MAX : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/nios2_c_rr_arbiter2.sv
// Two-way round-robin grant selection; a lone requester always wins,
// on contention the requester that was not granted last wins.
module nios2_c_rr_arbiter2
    import nios2_c_onchip_memory_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == REQ_M1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/nios2_c_onchip_memory_arbiter.sv
// Arbitrates two Avalon-style masters onto one single-port on-chip memory with
// optional bus locking, 1-cycle read return, range checking and error counting.
module nios2_c_onchip_memory_arbiter
    import nios2_c_onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic              m0_lock,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic              m1_lock,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic [ERR_W-1:0]  err_count
);

    localparam int               CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);

    arb_state_e       state_q,      state_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic             rd_vld_q,     rd_vld_d;
    req_id_t          rd_owner_q,   rd_owner_d;
    logic             rd_oor_q,     rd_oor_d;
    logic [ERR_W-1:0] err_q,        err_d;

    logic [1:0]        req_vec;
    logic [1:0]        rr_grant;
    logic [1:0]        grant;
    logic              arb_en;
    logic              accepted;
    req_id_t           sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic              cmd_lock;
    logic              cmd_oor;
    logic              owner_lock;
    logic              timeout;
    logic [DATA_W-1:0] rd_data;

    assign req_vec = {m1_read | m1_write, m0_read | m0_write};
    assign arb_en  = reset_n && (state_q == ST_ARB);

    nios2_c_rr_arbiter2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .grant      (rr_grant)
    );

    // While locked only the owner can be granted; nothing is granted during reset.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            case (state_q)
                ST_ARB:   grant = rr_grant;
                ST_LOCK0: grant = {1'b0, req_vec[0]};
                ST_LOCK1: grant = {req_vec[1], 1'b0};
                default:  grant = 2'b00;
            endcase
        end
    end

    assign accepted   = |grant;
    assign sel        = grant[1];
    assign cmd_addr   = sel ? m1_address : m0_address;
    assign cmd_write  = sel ? m1_write   : m0_write;
    assign cmd_lock   = sel ? m1_lock    : m0_lock;
    assign cmd_oor    = 32'(cmd_addr) >= DEPTH_U;
    assign owner_lock = (state_q == ST_LOCK1) ? m1_lock : m0_lock;

    assign m0_waitrequest = ~grant[0];
    assign m1_waitrequest = ~grant[1];

    assign mem_address    = cmd_addr;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
    assign mem_chipselect = accepted & ~cmd_oor;
    assign mem_write      = accepted & ~cmd_oor & cmd_write;
    assign mem_clken      = reset_n;

    assign rd_data          = rd_oor_q ? '0 : mem_readdata;
    assign m0_readdatavalid = reset_n & rd_vld_q & (rd_owner_q == REQ_M0);
    assign m1_readdatavalid = reset_n & rd_vld_q & (rd_owner_q == REQ_M1);
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

    assign err_count = err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        timeout      = 1'b0;

        if (accepted) begin
            last_grant_d = sel;
        end

        case (state_q)
            ST_ARB: begin
                if (accepted && cmd_lock) begin
                    state_d    = sel ? ST_LOCK1 : ST_LOCK0;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (!owner_lock) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                    timeout    = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Out-of-range reads still occupy the return slot so the master sees a zero reply.
    always_comb begin
        rd_vld_d   = accepted & ~cmd_write;
        rd_owner_d = sel;
        rd_oor_d   = cmd_oor;
        err_d      = err_add(err_q, {1'b0, accepted & cmd_oor} + {1'b0, timeout});
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q      <= ST_ARB;
            last_grant_q <= REQ_M1;
            lock_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            rd_owner_q   <= REQ_M0;
            rd_oor_q     <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_nios2_c_onchip_memory_arbiter.sv
// Directed bench for the two-master memory arbiter: a cycle table for basic traffic,
// then hand-written sequences for locking, timeout, saturation and mid-read reset.
module tb_nios2_c_onchip_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [16:0] m0_address,     m1_address;
    logic [3:0]  m0_byteenable,  m1_byteenable;
    logic        m0_read,        m1_read;
    logic        m0_write,       m1_write;
    logic        m0_lock,        m1_lock;
    logic [31:0] m0_writedata,   m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata,    m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [16:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic [7:0]  err_count;

    nios2_c_onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_lock          (m0_lock),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_lock          (m1_lock),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 128 words aliased on the low address bits, registered read.
    logic [31:0] mem_model [128];
    logic [31:0] mem_rdata_q;
    assign mem_readdata = mem_rdata_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write)
                mem_model[mem_address[6:0]] <= merge(mem_model[mem_address[6:0]], mem_writedata, mem_byteenable);
            else
                mem_rdata_q <= mem_model[mem_address[6:0]];
        end
    end

    logic [1:0] wait_v, rdv_v;
    assign wait_v = {m1_waitrequest, m0_waitrequest};
    assign rdv_v  = {m1_readdatavalid, m0_readdatavalid};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [1:0] lk, input logic [16:0] a0, input logic [16:0] a1,
                         input logic [3:0] be0, input logic [31:0] wd0);
        reset_n       = rst;
        m0_read       = rd[0];
        m1_read       = rd[1];
        m0_write      = wr[0];
        m1_write      = wr[1];
        m0_lock       = lk[0];
        m1_lock       = lk[1];
        m0_address    = a0;
        m1_address    = a1;
        m0_byteenable = be0;
        m0_writedata  = wd0;
        m1_byteenable = 4'hF;
        m1_writedata  = 32'h0BAD_F00D;
    endtask

    typedef struct packed {
        logic        rst;
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [1:0]  lk;
        logic [16:0] a0;
        logic [16:0] a1;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [1:0]  e_wait;
        logic        e_cs;
        logic        e_we;
        logic [1:0]  e_rdv;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [7:0]  e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 128; k++) mem_model[k] = 32'hC0DE_0000 + 32'(k);
        mem_rdata_q = 32'h0;
        drive(1'b0, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0);

        //            rst   rd     wr     lk     a0          a1           be0   wd0            wait   cs    we    rdv    rd0            rd1            err
        vecs[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 17'd1,     17'd2,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 17'd1,     17'd2,      4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 17'd1,     17'd2,      4'hF, 32'h0,         2'b01, 1'b1, 1'b0, 2'b01, 32'hC0DE_0001, 32'h0,         8'd0};
        vecs[3]  = '{1'b1, 2'b11, 2'b00, 2'b00, 17'd1,     17'd2,      4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 2'b10, 32'h0,         32'hC0DE_0002, 8'd0};
        vecs[4]  = '{1'b1, 2'b00, 2'b01, 2'b00, 17'd5,     17'd0,      4'h3, 32'hA5A5_A5A5, 2'b10, 1'b1, 1'b1, 2'b01, 32'hC0DE_0001, 32'h0,         8'd0};
        vecs[5]  = '{1'b1, 2'b11, 2'b00, 2'b00, 17'd5,     17'd3,      4'hF, 32'h0,         2'b01, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[6]  = '{1'b1, 2'b01, 2'b00, 2'b00, 17'd5,     17'd0,      4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 2'b10, 32'h0,         32'hC0DE_0003, 8'd0};
        vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 17'd0,     17'd0,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b01, 32'hC0DE_A5A5, 32'h0,         8'd0};
        vecs[8]  = '{1'b1, 2'b10, 2'b10, 2'b00, 17'd0,     17'd7,      4'hF, 32'h0,         2'b01, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[9]  = '{1'b1, 2'b10, 2'b00, 2'b00, 17'd0,     17'd7,      4'hF, 32'h0,         2'b01, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[10] = '{1'b1, 2'b00, 2'b00, 2'b00, 17'd0,     17'd0,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b10, 32'h0,         32'h0BAD_F00D, 8'd0};
        vecs[11] = '{1'b1, 2'b01, 2'b00, 2'b00, 17'd75000, 17'd0,      4'hF, 32'h0,         2'b10, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         8'd0};
        vecs[12] = '{1'b1, 2'b00, 2'b00, 2'b00, 17'd0,     17'd0,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b01, 32'h0,         32'h0,         8'd1};
        vecs[13] = '{1'b1, 2'b00, 2'b10, 2'b00, 17'd0,     17'd100000, 4'hF, 32'h0,         2'b01, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         8'd1};
        vecs[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 17'd0,     17'd0,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         8'd2};
        vecs[15] = '{1'b1, 2'b01, 2'b00, 2'b00, 17'd74999, 17'd0,      4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0,         8'd2};
        vecs[16] = '{1'b1, 2'b00, 2'b00, 2'b00, 17'd0,     17'd0,      4'hF, 32'h0,         2'b11, 1'b0, 1'b0, 2'b01, 32'hC0DE_0077, 32'h0,         8'd2};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].lk, vecs[i].a0, vecs[i].a1,
                  vecs[i].be0, vecs[i].wd0);
            #1;
            check($sformatf("v%0d wait", i),  32'(wait_v),         32'(vecs[i].e_wait));
            check($sformatf("v%0d cs", i),    32'(mem_chipselect), 32'(vecs[i].e_cs));
            check($sformatf("v%0d we", i),    32'(mem_write),      32'(vecs[i].e_we));
            check($sformatf("v%0d clken", i), 32'(mem_clken),      32'(vecs[i].rst));
            check($sformatf("v%0d rdv", i),   32'(rdv_v),          32'(vecs[i].e_rdv));
            check($sformatf("v%0d rd0", i),   m0_readdata,         vecs[i].e_rd0);
            check($sformatf("v%0d rd1", i),   m1_readdata,         vecs[i].e_rd1);
            check($sformatf("v%0d err", i),   32'(err_count),      32'(vecs[i].e_err));
        end

        // Lock timeout from a clean reset: m0 locks, m1 keeps asking.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b0, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0);
        end
        @(negedge clk); drive(1'b1, 2'b11, 2'b00, 2'b01, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("to enter wait", 32'(wait_v), 32'(2'b10));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); drive(1'b1, 2'b11, 2'b00, 2'b01, 17'd1, 17'd2, 4'hF, 32'h0); #1;
            check($sformatf("to hold%0d wait", i), 32'(wait_v), 32'(2'b10));
        end
        @(negedge clk); drive(1'b1, 2'b11, 2'b00, 2'b01, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("to release wait", 32'(wait_v), 32'(2'b01));
        check("to release err", 32'(err_count), 32'd1);
        @(negedge clk); drive(1'b1, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0); #1;
        check("to idle err", 32'(err_count), 32'd1);

        // m1 holds the lock for three commands while m0 waits.
        @(negedge clk); drive(1'b1, 2'b01, 2'b00, 2'b00, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("lk pre wait", 32'(wait_v), 32'(2'b10));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b1, 2'b11, 2'b00, 2'b10, 17'd1, 17'd2, 4'hF, 32'h0); #1;
            check($sformatf("lk cmd%0d wait", i), 32'(wait_v), 32'(2'b01));
        end
        @(negedge clk); drive(1'b1, 2'b01, 2'b00, 2'b00, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("lk drop wait", 32'(wait_v), 32'(2'b11));
        check("lk drop rdv1", 32'(m1_readdatavalid), 32'd1);
        check("lk drop rd1", m1_readdata, 32'hC0DE_0002);
        @(negedge clk); drive(1'b1, 2'b01, 2'b00, 2'b00, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("lk after wait", 32'(wait_v), 32'(2'b10));

        // Timeout and out-of-range access land in the same cycle: +2.
        @(negedge clk); drive(1'b1, 2'b01, 2'b00, 2'b01, 17'd1, 17'd2, 4'hF, 32'h0); #1;
        check("dbl enter wait", 32'(wait_v), 32'(2'b10));
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            drive(1'b1, 2'b11, 2'b00, 2'b01, (i == 16) ? 17'd75000 : 17'd1, 17'd2, 4'hF, 32'h0);
            #1;
            check($sformatf("dbl hold%0d wait", i), 32'(wait_v), 32'(2'b10));
            if (i == 16) check("dbl oor cs", 32'(mem_chipselect), 32'd0);
        end
        @(negedge clk); drive(1'b1, 2'b10, 2'b00, 2'b00, 17'd0, 17'd2, 4'hF, 32'h0); #1;
        check("dbl release wait", 32'(wait_v), 32'(2'b01));
        check("dbl err", 32'(err_count), 32'd3);
        check("dbl rdv0", 32'(m0_readdatavalid), 32'd1);
        check("dbl rd0", m0_readdata, 32'h0);

        // 300 out-of-range reads saturate the error count.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); drive(1'b1, 2'b10, 2'b00, 2'b00, 17'd0, 17'd75000, 4'hF, 32'h0); #1;
            check($sformatf("sat%0d cs", i), 32'(mem_chipselect), 32'd0);
        end
        @(negedge clk); drive(1'b1, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0); #1;
        check("sat err", 32'(err_count), 32'd255);
        check("sat rdv1", 32'(m1_readdatavalid), 32'd1);
        check("sat rd1", m1_readdata, 32'h0);

        // Reset right after an accepted read drops the pending return.
        @(negedge clk); drive(1'b1, 2'b01, 2'b00, 2'b00, 17'd2, 17'd0, 4'hF, 32'h0); #1;
        check("rst rd accept cs", 32'(mem_chipselect), 32'd1);
        @(negedge clk); drive(1'b0, 2'b01, 2'b00, 2'b00, 17'd2, 17'd0, 4'hF, 32'h0); #1;
        check("rst wait", 32'(wait_v), 32'(2'b11));
        check("rst rdv", 32'(rdv_v), 32'(2'b00));
        check("rst rd0", m0_readdata, 32'h0);
        check("rst cs", 32'(mem_chipselect), 32'd0);
        check("rst we", 32'(mem_write), 32'd0);
        check("rst clken", 32'(mem_clken), 32'd0);
        @(negedge clk); drive(1'b0, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0); #1;
        check("rst err", 32'(err_count), 32'd0);
        @(negedge clk); drive(1'b1, 2'b00, 2'b00, 2'b00, 17'd0, 17'd0, 4'hF, 32'h0); #1;
        check("post rst rdv", 32'(rdv_v), 32'(2'b00));
        check("post rst clken", 32'(mem_clken), 32'd1);
        check("post rst wait", 32'(wait_v), 32'(2'b11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios2_c_onchip_memory_arbiter.md
NIOS2_C_ONCHIP_MEMORY_ARBITER -- requirements
Module: nios2_c_onchip_memory_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 17, word address width; DATA_W, default 32, data width; DEPTH, default 75000, implemented words; LOCK_MAX, default 16, maximum cycles a lock may be held.
REQ-002 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports, per requester x in {0,1}:
- mx_address  in  ADDR_W  word address.
- mx_byteenable  in  4  byte lanes.
- mx_read  in  1  read request.
- mx_write  in  1  write request.
- mx_lock  in  1  hold the grant.
- mx_writedata  in  DATA_W  write data.
- mx_waitrequest  out  1  request not accepted this cycle.
- mx_readdata  out  DATA_W  read data.
- mx_readdatavalid  out  1  readdata qualifier.
REQ-005 SHALL have memory-side ports:
- mem_address  out  ADDR_W.
- mem_byteenable  out  4.
- mem_chipselect  out  1.
- mem_write  out  1.
- mem_writedata  out  DATA_W.
- mem_clken  out  1.
- mem_readdata  in  DATA_W.
REQ-006 SHALL have ports: err_count  out  8  saturating count of out-of-range accesses and lock timeouts.

Function
REQ-007 SHALL accept at most one command per cycle; a command is accepted when (mx_read|mx_write) is high and mx_waitrequest is low; mx_read and mx_write both high SHALL be treated as a write.
REQ-008 mx_waitrequest SHALL be combinational: low only for the granted requester; high for a requester that is not granted.
REQ-009 FSM states: ARB, LOCK0, LOCK1.
REQ-010 In ARB:
- A single requester wins.
- If both request, the requester not granted last wins (round-robin).
- last_grant SHALL update on every accepted command.
REQ-011 An accepted command with mx_lock=1 SHALL move the FSM ARB->LOCKx.
REQ-012 In LOCKx only requester x SHALL be grantable; the other requester SHALL see waitrequest=1.
REQ-013 LOCKx->ARB transitions SHALL occur on whichever comes first:
- the first cycle mx_lock=0;
- the lock cycle counter reaching LOCK_MAX (timeout). A timeout SHALL increment err_count.
REQ-014 Accepted command SHALL drive the memory-side ports in the same cycle:
- mem_chipselect=1;
- mem_write=write;
- address, byteenable and writedata passed through from the granted requester.
With no accepted command, mem_chipselect=0 and mem_write=0.
REQ-015 Read latency SHALL be exactly 1 cycle: a read accepted in cycle N SHALL produce mx_readdatavalid=1 and mx_readdata=mem_readdata in cycle N+1, for the owning requester only.
REQ-016 The read owner SHALL be tracked in a 1-deep pipeline register; back-to-back reads, including alternating requesters, SHALL sustain 1 per cycle.
REQ-017 An accepted command with address >= DEPTH:
- SHALL be accepted but not forwarded (mem_chipselect=0);
- a read SHALL return readdatavalid with readdata=0;
- err_count SHALL increment.
REQ-018 err_count SHALL saturate at 255.
REQ-019 When one cycle has both an out-of-range access and a lock timeout, err_count SHALL increment by 2, still saturating at 255.
REQ-020 mem_clken SHALL be 1 except in the reset cycle.
REQ-021 mx_readdata SHALL be 0 whenever mx_readdatavalid=0.

Reset
REQ-022 While reset_n=0 at a clock edge, the block SHALL set:
- FSM=ARB, last_grant=1 (so m0 wins first), lock counter=0, read pipeline empty, err_count=0;
- all waitrequest=1, readdatavalid=0, mem_chipselect=0, mem_write=0.
REQ-023 A read accepted in the cycle before reset SHALL NOT produce readdatavalid after reset.
REQ-024 Reset SHALL abandon any held lock.

Structure
REQ-025 A shared package SHALL hold: the FSM state enum, the requester-id type, and the constants ERR_W=8 and the default DEPTH.
REQ-026 Round-robin grant selection SHALL be a sub-module, nios2_c_rr_arbiter2: inputs req[1:0], last_grant, enable; output grant[1:0] one-hot.
REQ-027 FSM, lock counter, read pipeline and error counter SHALL reside in the top module.

Verification
REQ-028 m0 and m1 read simultaneously and continuously after reset -> grants alternate m0,m1,m0...; each readdatavalid arrives 1 cycle after its acceptance.
REQ-029 m0 writes 0xA5A5A5A5 to addr 5 with byteenable 4'b0011, then reads addr 5 -> readdata[15:0]=0xA5A5 and the upper bytes are unchanged.
REQ-030 m1 asserts lock for 3 accepted commands while m0 requests -> m0 waitrequest=1 throughout; m0 is granted in the cycle after m1 lock drops.
REQ-031 m0 holds lock for LOCK_MAX+2 cycles -> forced return to ARB after LOCK_MAX cycles; err_count=1; m1 is then granted.
REQ-032 m1 reads addr 75000 -> mem_chipselect=0, readdatavalid=1 with readdata=0, err_count increments; 300 such reads -> err_count=255.
REQ-033 Read accepted, then reset_n=0 the next cycle -> no readdatavalid; all outputs at reset values.
